blink_array: RTL

BLINK_ARRAY -- requirements
Module: blink_array

---
 rtl/blink_pkg.sv | 33 +++
 rtl/blink_chan.sv | 124 ++++++++++++
 rtl/blink_array.sv | 80 ++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared encodings for the blink_array LED controller: configuration modes,
// per-channel states and the state-to-output mapping.
package blink_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BURST = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STEADY = 2'd1,
      ST_HIGH   = 2'd2,
      ST_LOW    = 2'd3
   } chan_state_t;

   function automatic logic state_led(input chan_state_t s);
      case (s)
         ST_STEADY, ST_HIGH: state_led = 1'b1;
         default:            state_led = 1'b0;
      endcase
   endfunction

   function automatic logic state_busy(input chan_state_t s);
      case (s)
         ST_HIGH, ST_LOW: state_busy = 1'b1;
         default:         state_busy = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/blink_chan.sv
// One LED channel: steady on/off, free-running blink or counted burst,
// advanced by the shared base tick.
module blink_chan
   import blink_pkg::*;
#(
   parameter int HW = 16,
   parameter int BW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          load,
   input  mode_t         mode,
   input  logic [HW-1:0] half,
   input  logic [BW-1:0] count,
   output logic          led,
   output logic          busy,
   output logic          done
);

   localparam logic [HW-1:0] HONE = HW'(1);
   localparam logic [BW-1:0] RONE = BW'(1);

   chan_state_t   state_r, state_s;
   logic [HW-1:0] phase_r, phase_s;
   logic [HW-1:0] half_r, half_s;
   logic [BW-1:0] rem_r, rem_s;
   logic          burst_r, burst_s;
   logic          done_s;
   logic          led_r, busy_r, done_r;

   // Next-state: a load always wins over the tick, so reconfiguring aborts silently.
   always_comb begin
      state_s = state_r;
      phase_s = phase_r;
      half_s  = half_r;
      rem_s   = rem_r;
      burst_s = burst_r;
      done_s  = 1'b0;
      if (load) begin
         phase_s = {HW{1'b0}};
         half_s  = (half == {HW{1'b0}}) ? HONE : half;
         case (mode)
            MODE_OFF: begin
               state_s = ST_IDLE;
               burst_s = 1'b0;
            end
            MODE_ON: begin
               state_s = ST_STEADY;
               burst_s = 1'b0;
            end
            MODE_BLINK: begin
               state_s = ST_HIGH;
               burst_s = 1'b0;
            end
            MODE_BURST: begin
               if (count == {BW{1'b0}}) begin
                  state_s = ST_IDLE;
                  burst_s = 1'b0;
                  done_s  = 1'b1;
               end else begin
                  state_s = ST_HIGH;
                  burst_s = 1'b1;
                  rem_s   = count;
               end
            end
            default: begin
               state_s = ST_IDLE;
               burst_s = 1'b0;
            end
         endcase
      end else if (tick && state_busy(state_r)) begin
         if ((phase_r + HONE) == half_r) begin
            phase_s = {HW{1'b0}};
            if (state_r == ST_HIGH) begin
               state_s = ST_LOW;
               if (burst_r) begin
                  rem_s = rem_r - RONE;
               end else begin
                  rem_s = rem_r;
               end
            end else if (burst_r && (rem_r == {BW{1'b0}})) begin
               state_s = ST_IDLE;
               burst_s = 1'b0;
               done_s  = 1'b1;
            end else begin
               state_s = ST_HIGH;
            end
         end else begin
            phase_s = phase_r + HONE;
         end
      end else begin
         state_s = state_r;
      end
   end

   // State registers; outputs are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         phase_r <= {HW{1'b0}};
         half_r  <= HONE;
         rem_r   <= {BW{1'b0}};
         burst_r <= 1'b0;
         led_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         phase_r <= phase_s;
         half_r  <= half_s;
         rem_r   <= rem_s;
         burst_r <= burst_s;
         led_r   <= state_led(state_s);
         busy_r  <= state_busy(state_s);
         done_r  <= done_s;
      end
   end

   assign led  = led_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: rtl/blink_array.sv
// Multi-channel LED blinker: shared base-tick prescaler, configuration decode
// and one blink_chan per channel.
module blink_array
   import blink_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int CDIV = 50_000,
   parameter int HW   = 16,
   parameter int BW   = 8,
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [CW-1:0]  cfg_ch,
   input  logic [1:0]     cfg_mode,
   input  logic [HW-1:0]  cfg_half,
   input  logic [BW-1:0]  cfg_count,
   output logic [NCH-1:0] led,
   output logic [NCH-1:0] busy,
   output logic [NCH-1:0] done
);

   localparam int            PW   = $clog2(CDIV);
   localparam logic [PW-1:0] CMAX = PW'(CDIV - 1);

   logic [PW-1:0] cnt_r;
   logic          tick_s;
   logic          ready_r;
   logic          accept_s;

   assign tick_s   = (cnt_r == CMAX);
   assign accept_s = cfg_valid & ready_r;

   // Base-tick prescaler, free running and never touched by configuration.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {PW{1'b0}};
      end else if (tick_s) begin
         cnt_r <= {PW{1'b0}};
      end else begin
         cnt_r <= cnt_r + PW'(1);
      end
   end

   // Ready is low only for the cycle following a reset edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_r <= 1'b0;
      end else begin
         ready_r <= 1'b1;
      end
   end

   assign cfg_ready = ready_r;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic load_s;
      // Out-of-range channel numbers simply match no channel.
      assign load_s = accept_s & (32'(cfg_ch) == i);

      blink_chan #(
         .HW(HW),
         .BW(BW)
      ) u_chan (
         .clk  (clk),
         .rst  (rst),
         .tick (tick_s),
         .load (load_s),
         .mode (mode_t'(cfg_mode)),
         .half (cfg_half),
         .count(cfg_count),
         .led  (led[i]),
         .busy (busy[i]),
         .done (done[i])
      );
   end

endmodule
